bram_delay_ctrl: RTL and testbench
==================================

Name: bram_delay_ctrl

Overview:
- Address and enable sequencer for a simple-dual-port BRAM used as a runtime-programmable delay line.
- Generates write/read addresses, enables and an output-valid flag so the BRAM output equals the input delayed by a configured number of ce-qualified clocks.
- Accepts new delay values through a valid/ready handshake and re-primes the line safely, so downstream never sees stale data flagged valid.
- Sits between the config/control bus and a BRAM_SDP_MACRO instance; the macro's DO_REG must match LATENCY.

Parameters:
- ADDR_BITS, 10, BRAM address width; maximum delay is 2^ADDR_BITS.
- LATENCY, 2, BRAM read latency in clocks; legal values are 1 or 2.

Ports:
- clk, input, 1, clock for the block and the BRAM.
- rst_n, input, 1, asynchronous active-low reset.
- ce, input, 1, clock enable; all sequencing advances only when ce=1.
- cfg_delay, input, ADDR_BITS+1, requested delay in ce-cycles.
- cfg_valid, input, 1, cfg_delay is valid.
- cfg_ready, output, 1, block can accept a config this cycle.
- cfg_err, output, 1, one-cycle pulse when an accepted cfg_delay is illegal.
- stop, input, 1, synchronous request to halt and return to IDLE.
- wr_addr, output, ADDR_BITS, BRAM write address.
- rd_addr, output, ADDR_BITS, BRAM read address.
- wren, output, 1, BRAM write enable.
- rden, output, 1, BRAM read enable.
- dout_valid, output, 1, BRAM DO currently holds valid delayed data.
- cur_delay, output, ADDR_BITS+1, delay currently in force (0 when none).
- state_o, output, 2, current state: 0=IDLE, 1=FILL, 2=RUN.

Behaviour:
- **Reset values:** state IDLE, ctr=0, fill_cnt=0, cur_delay=0, cfg_err=0, dout_valid=0. With rst_n low, cfg_ready=0 and wren=rden=0.
- **Address generation:**
  - wr_addr=ctr.
  - rd_addr=(ctr-(cur_delay-LATENCY)) mod 2^ADDR_BITS. Both are combinational from registers.
  - ctr increments mod 2^ADDR_BITS on clocks where ce=1 and state is FILL or RUN. It wraps silently.
- **Enables:** wren=rden=ce while state is FILL or RUN; both are 0 in IDLE.
- **Handshake:**
  - cfg_ready=~stop when out of reset, in every state.
  - Transfer occurs when cfg_valid & cfg_ready, independent of ce.
- **Legal delay:** LATENCY+1 <= cfg_delay <= 2^ADDR_BITS.
  - On an illegal transfer: cfg_err=1 on the next clock for exactly one cycle; state, cur_delay and ctr are unchanged.
  - On a legal transfer: cur_delay<=cfg_delay, fill_cnt<=0, state<=FILL, dout_valid<=0 next clock. This applies from IDLE, FILL or RUN. ctr is not reset, so addressing stays continuous.
- **IDLE:** waits for a legal config.
- **FILL:**
  - On each ce=1 clock, fill_cnt++.
  - When fill_cnt==cur_delay-1 with ce=1, the next state is RUN.
  - Result: the sample written on the first FILL ce-cycle appears on DO exactly cur_delay ce-cycles later.
- **RUN:** dout_valid=1 (registered, equal to state==RUN); it stays there until stop or a new legal config.
- **stop=1:**
  - Next clock: state IDLE, dout_valid=0, cur_delay=0. ctr holds its value.
  - stop has priority over a simultaneous cfg_valid, which is not accepted because cfg_ready=0.
- **ce=0:** all registers hold, except the handshake and the cfg_err pulse, which still operate.
- **Async reset mid-operation:** all registers return immediately to their reset values. Any config in flight is lost.

Test Plan (ADDR_BITS=4, LATENCY=2 unless stated):
- **Reset then config 5, ce=1:**
  - cfg_ready=0 during reset and 1 after.
  - FILL for 5 clocks, then RUN with dout_valid=1.
  - Behavioural BRAM model: input ramp 0,1,2… gives dout = din delayed by 5.
- **Boundary delays 3 and 16:**
  - Both accepted; rd_addr = wr_addr-1 and wr_addr-14 mod 16 respectively.
  - Output is exactly delayed by 3 and by 16 across ctr wrap 15->0.
- **Illegal delays 2, 17 and 0:**
  - cfg_err pulses for one cycle each.
  - state, cur_delay and outputs are unchanged while in RUN with delay 5.
- **Reconfigure 5->9 in RUN:**
  - dout_valid drops the next clock and stays low for 9 ce-cycles.
  - RUN resumes with the correct 9-cycle delay and ctr is continuous.
- **ce toggling 1,0,1,0 during FILL with delay 4:**
  - RUN is reached after 4 ce=1 clocks (8 clocks).
  - ctr and fill_cnt hold when ce=0.
- **stop asserted with cfg_valid=1 (delay 6) in RUN:**
  - cfg_ready=0 and the config is not accepted.
  - Next state IDLE, cur_delay=0, wren=rden=0.
  - Async rst_n pulse mid-FILL returns all outputs to reset values in the same cycle.

Source files
------------

// File: rtl/bram_delay_ctrl_if.sv
// rtl/bram_delay_ctrl_if.sv - delay configuration handshake bundle
//
// Purpose: carries the delay-configuration valid/ready handshake and the
//          illegal-config error pulse between a control master and the
//          delay-line sequencer.
// Signals:
//   cfg_delay [ADDR_BITS:0]  requested delay in ce-cycles (master -> slave)
//   cfg_valid                cfg_delay is valid         (master -> slave)
//   cfg_ready                slave accepts this cycle   (slave -> master)
//   cfg_err                  one-cycle illegal pulse    (slave -> master)
interface bram_delay_ctrl_if #(
  parameter int ADDR_BITS = 10
) ();
  logic [ADDR_BITS:0] cfg_delay;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_err;

  modport master (
    output cfg_delay,
    output cfg_valid,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_delay,
    input  cfg_valid,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/bram_delay_ctrl.sv
// rtl/bram_delay_ctrl.sv - address/enable sequencer for a BRAM delay line
//
// Purpose: drives a simple-dual-port BRAM so that its output equals the
//          input delayed by a runtime-programmable number of ce-cycles.
//          A new legal delay re-primes the line (FILL) before the output
//          is flagged valid again (RUN).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ce           clock enable; sequencing advances only when high
//   cfg          delay config handshake (slave modport)
//   stop         synchronous request to return to IDLE
//   wr_addr      BRAM write address
//   rd_addr      BRAM read address
//   wren, rden   BRAM write / read enables
//   dout_valid   BRAM DO holds valid delayed data
//   cur_delay    delay in force, 0 when idle
//   state_o      0=IDLE, 1=FILL, 2=RUN
module bram_delay_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  bram_delay_ctrl_if.slave     cfg,
  input  logic                 stop,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 wren,
  output logic                 rden,
  output logic                 dout_valid,
  output logic [ADDR_BITS:0]   cur_delay,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_BITS:0]   MIN_DELAY = (ADDR_BITS+1)'(LATENCY + 1);
  localparam logic [ADDR_BITS:0]   MAX_DELAY = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   D_ONE     = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] A_ONE     = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LAT_A     = ADDR_BITS'(LATENCY);

  state_t               state;
  logic [ADDR_BITS-1:0] ctr;
  logic [ADDR_BITS:0]   fill_cnt;
  logic                 err_q;

  logic active;
  logic xfer;
  logic legal;

  assign active = (state != IDLE);

  // Ready is held low in reset so nothing can be accepted before the
  // sequencer is live; stop blocks acceptance so stop always wins.
  assign cfg.cfg_ready = rst_n & ~stop;
  assign cfg.cfg_err   = err_q;

  assign xfer  = cfg.cfg_valid & cfg.cfg_ready;
  assign legal = (cfg.cfg_delay >= MIN_DELAY) && (cfg.cfg_delay <= MAX_DELAY);

  assign wr_addr = ctr;
  // Read sits (delay - LATENCY) behind the write so the BRAM pipeline makes
  // up the remaining LATENCY cycles. A delay of 2^ADDR_BITS has zero low
  // bits, which gives the same result modulo the address space.
  assign rd_addr = ctr - cur_delay[ADDR_BITS-1:0] + LAT_A;

  assign wren    = ce & active;
  assign rden    = ce & active;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ctr        <= '0;
      fill_cnt   <= '0;
      cur_delay  <= '0;
      err_q      <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (stop) begin
        // ctr is kept so addressing resumes where it left off.
        state      <= IDLE;
        cur_delay  <= '0;
        fill_cnt   <= '0;
        dout_valid <= 1'b0;
      end else begin
        if (ce && active) begin
          ctr <= ctr + A_ONE;
        end
        if (xfer && legal) begin
          // Re-prime from any state; ctr continues so no address jump.
          state      <= FILL;
          cur_delay  <= cfg.cfg_delay;
          fill_cnt   <= '0;
          dout_valid <= 1'b0;
        end else begin
          if (xfer) begin
            err_q <= 1'b1;
          end
          if (ce && state == FILL) begin
            fill_cnt <= fill_cnt + D_ONE;
            // cur_delay ce-cycles of writes have landed once this count
            // completes, so the first FILL sample reaches DO in RUN.
            if (fill_cnt == cur_delay - D_ONE) begin
              state      <= RUN;
              dout_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// tb/tb_bram_delay_ctrl.sv - randomized self-checking bench for bram_delay_ctrl
module tb_bram_delay_ctrl;

  localparam int AB   = 4;
  localparam int LAT  = 2;
  localparam int MASK = (1 << AB) - 1;
  localparam int MAXD = 1 << AB;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic          stop;
  logic [AB-1:0] wr_addr;
  logic [AB-1:0] rd_addr;
  logic          wren;
  logic          rden;
  logic          dout_valid;
  logic [AB:0]   cur_delay;
  logic [1:0]    state_o;
  logic [7:0]    din;

  bram_delay_ctrl_if #(.ADDR_BITS(AB)) cfg_bus ();

  bram_delay_ctrl #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .cfg        (cfg_bus),
    .stop       (stop),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .wren       (wren),
    .rden       (rden),
    .dout_valid (dout_valid),
    .cur_delay  (cur_delay),
    .state_o    (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SDP BRAM with a two-stage read pipeline (DO_REG=1).
  logic [7:0] mem [MAXD];
  logic [7:0] do_s1;
  logic [7:0] bram_do;
  always @(posedge clk) begin
    if (wren) mem[wr_addr] <= din;
    if (rden) begin
      do_s1   <= mem[rd_addr];
      bram_do <= do_s1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode, delay in force, remaining fill cycles, write
  // position, and the history of every sample written at an advancing slot.
  int m_state, m_delay, m_fill_left, m_ctr, m_err;
  int hist[$];

  function automatic bit is_legal(input int d);
    return (d >= LAT + 1) && (d <= MAXD);
  endfunction

  task automatic model_reset();
    m_state = 0; m_delay = 0; m_fill_left = 0; m_ctr = 0; m_err = 0;
    hist.delete();
  endtask

  task automatic model_update(input bit c, input bit s, input bit v, input int d, input int dv);
    int  old;
    bit  adv;
    old   = m_state;
    adv   = 1'b0;
    m_err = 0;
    if (s) begin
      m_state = 0;
      m_delay = 0;
    end else begin
      adv = c && (old != 0);
      if (v && is_legal(d)) begin
        m_state     = 1;
        m_delay     = d;
        m_fill_left = d;
      end else begin
        if (v) m_err = 1;
        if (c && old == 1) begin
          m_fill_left--;
          if (m_fill_left == 0) m_state = 2;
        end
      end
    end
    if (adv) begin
      hist.push_back(dv);
      m_ctr = (m_ctr + 1) & MASK;
    end
  endtask

  task automatic check_outputs();
    check_val("state", state_o, m_state);
    check_val("cur_delay", cur_delay, m_delay);
    check_val("wr_addr", wr_addr, m_ctr);
    check_val("rd_addr", rd_addr, (m_ctr - m_delay + LAT) & MASK);
    check_val("wren", wren, ce && (m_state != 0));
    check_val("rden", rden, ce && (m_state != 0));
    check_val("cfg_ready", cfg_bus.cfg_ready, !stop);
    check_val("cfg_err", cfg_bus.cfg_err, m_err);
    check_val("dout_valid", dout_valid, m_state == 2);
    if (m_state == 2 && hist.size() >= m_delay)
      check_val("dout", bram_do, hist[hist.size() - m_delay]);
  endtask

  // Called at a negedge: apply inputs, check, clock, advance the model.
  task automatic step(input bit c, input bit s, input bit v, input int d);
    int dv;
    ce                = c;
    stop              = s;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_delay = (AB+1)'(d);
    din               = 8'($urandom);
    dv                = int'(din);
    #1;
    check_outputs();
    @(posedge clk);
    model_update(c, s, v, d, dv);
    @(negedge clk);
  endtask

  task automatic run_ce(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, state_o, 0);
    check_val({tag, "_cur_delay"}, cur_delay, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_wren"}, wren, 0);
    check_val({tag, "_rden"}, rden, 0);
    check_val({tag, "_cfg_ready"}, cfg_bus.cfg_ready, 0);
    check_val({tag, "_cfg_err"}, cfg_bus.cfg_err, 0);
    check_val({tag, "_dout_valid"}, dout_valid, 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    ce                = 1'b1;
    stop              = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_delay = '0;
    din               = '0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Delay 5 from IDLE, then settle into RUN.
    step(1'b1, 1'b0, 1'b1, 5);
    run_ce(14);

    // Illegal delays while running with 5.
    step(1'b0, 1'b0, 1'b1, 2);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 17);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    run_ce(4);

    // Boundary delays, long enough to wrap the address space.
    step(1'b1, 1'b0, 1'b1, 3);
    run_ce(25);
    step(1'b1, 1'b0, 1'b1, 16);
    run_ce(40);

    // Reconfigure 5 -> 9 while in RUN.
    step(1'b1, 1'b0, 1'b1, 5);
    run_ce(10);
    step(1'b1, 1'b0, 1'b1, 9);
    run_ce(16);

    // ce alternating during a FILL of 4.
    step(1'b0, 1'b0, 1'b1, 4);
    for (int i = 0; i < 10; i++) step(i[0] == 1'b0, 1'b0, 1'b0, 0);
    run_ce(6);

    // stop wins over a simultaneous config.
    step(1'b1, 1'b1, 1'b1, 6);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);

    // Async reset in the middle of FILL.
    step(1'b1, 1'b0, 1'b1, 7);
    run_ce(3);
    #2;
    rst_n             = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; illegal configs are issued with ce low.
    for (int i = 0; i < 1500; i++) begin
      bit c, s, v;
      int d;
      c = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 24) == 0);
      d = $urandom_range(0, MAXD + 1);
      if (v && !is_legal(d)) c = 1'b0;
      step(c, s, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
